// File: rtl/rerouting_pkg.sv
// rerouting_pkg: shared state type and code-layout constants for the rerouting sequencer
// A rerouting code is {direction, lane_index}: MSB is direction, LSBs select the lane.
package rerouting_pkg;
  typedef enum logic {RR_IDLE, RR_ISSUE} rr_state_t;
  localparam logic RR_DIR_STV = 1'b0;
  localparam logic RR_DIR_VTS = 1'b1;
endpackage

// File: rtl/lowest_set_bit_enc.sv
// lowest_set_bit_enc: priority encoder returning the lowest set lane and whether it is the only one left
module lowest_set_bit_enc #(
  parameter int NUM_LANES = 4,
  localparam int LANE_W = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] mask,
  output logic [LANE_W-1:0]    idx,
  output logic                 any,
  output logic                 onehot_remaining
);
  always_comb begin
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (mask[i]) idx = LANE_W'(i);
  end
  assign any = |mask;
  assign onehot_remaining = any && ((mask & (mask - NUM_LANES'(1))) == '0);
endmodule

// File: rtl/rerouting_sequencer.sv
// rerouting_sequencer: walks a lane mask low-to-high issuing one {dir, lane} rerouting code per handshake
// Optional RR_PERF_CNT_EN adds saturating handshake/stall counters.
module rerouting_sequencer
  import rerouting_pkg::*;
#(
  parameter int NUM_LANES = 4,
  localparam int LANE_W = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_vts,
  input  logic [NUM_LANES-1:0] req_lane_mask,
  input  logic                 flush,
  output logic                 rr_valid,
  input  logic                 rr_ready,
  output logic                 rerouting_select,
  output logic [LANE_W:0]      rerouting_code,
  output logic                 rr_last,
  output logic                 busy,
  output logic                 done
`ifdef RR_PERF_CNT_EN
  ,
  output logic [31:0]          perf_moves,
  output logic [31:0]          perf_stalls
`endif
);
  rr_state_t state, state_n;
  logic [NUM_LANES-1:0] mask_q, mask_n;
  logic dir_q, dir_n, done_n;
  logic [LANE_W-1:0] idx;
  logic any, onehot;
  lowest_set_bit_enc #(.NUM_LANES(NUM_LANES)) u_enc (
    .mask(mask_q),
    .idx(idx),
    .any(any),
    .onehot_remaining(onehot)
  );
  // every output derives from registered state, never from rr_ready
  assign req_ready = state == RR_IDLE;
  assign rr_valid = state == RR_ISSUE && any;
  assign rerouting_select = rr_valid;
  assign busy = state != RR_IDLE;
  assign rerouting_code = rr_valid ? {dir_q, idx} : '0;
  assign rr_last = rr_valid && onehot;
  always_comb begin
    state_n = state;
    mask_n = mask_q;
    dir_n = dir_q;
    done_n = 1'b0;
    if (state == RR_IDLE) begin
      if (req_valid && !flush) begin
        mask_n = req_lane_mask;
        dir_n = req_vts;
        state_n = |req_lane_mask ? RR_ISSUE : RR_IDLE;
        done_n = ~|req_lane_mask;
      end
    end else if (flush) begin
      state_n = RR_IDLE;
      mask_n = '0;
    end else if (rr_ready) begin
      mask_n = mask_q & ~(NUM_LANES'(1) << idx);
      state_n = rr_last ? RR_IDLE : RR_ISSUE;
      done_n = rr_last;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RR_IDLE;
      mask_q <= '0;
      dir_q <= RR_DIR_STV;
      done <= 1'b0;
    end else begin
      state <= state_n;
      mask_q <= mask_n;
      dir_q <= dir_n;
      done <= done_n;
    end
  end
`ifdef RR_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_moves <= '0;
      perf_stalls <= '0;
    end else begin
      if (rr_valid && rr_ready && perf_moves != '1) perf_moves <= perf_moves + 32'd1;
      if (rr_valid && !rr_ready && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rerouting_sequencer.sv
// tb_rerouting_sequencer: queue scoreboard of expected codes per accepted request, checked by a negedge monitor
module tb_rerouting_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_vts = 1'b0, flush = 1'b0, rr_ready = 1'b0;
  logic [3:0] req_lane_mask = '0;
  logic req_ready, rr_valid, rerouting_select, rr_last, busy, done;
  logic [2:0] rerouting_code;
`ifdef RR_PERF_CNT_EN
  logic [31:0] perf_moves, perf_stalls;
  int unsigned m_moves = 0, m_stalls = 0;
`endif
  typedef struct {logic [2:0] code; logic last; logic empty;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic done_pend = 1'b0, acc_pend = 1'b0, acc_dir = 1'b0;
  logic [3:0] acc_mask = '0;
  rerouting_sequencer #(.NUM_LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vts(req_vts), .req_lane_mask(req_lane_mask), .flush(flush),
    .rr_valid(rr_valid), .rr_ready(rr_ready), .rerouting_select(rerouting_select),
    .rerouting_code(rerouting_code), .rr_last(rr_last), .busy(busy), .done(done)
`ifdef RR_PERF_CNT_EN
    , .perf_moves(perf_moves), .perf_stalls(perf_stalls)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // reference: a request expands into one code per set lane, ascending, last on the highest lane
  task automatic push_req(input logic d, input logic [3:0] m);
    int h = -1;
    exp_t e;
    for (int i = 0; i < 4; i++) if (m[i]) h = i;
    if (h < 0) begin
      e.code = '0; e.last = 1'b0; e.empty = 1'b1;
      q.push_back(e);
    end
    for (int i = 0; i < 4; i++) if (m[i]) begin
      e.code = {d, i[1:0]}; e.last = (i == h); e.empty = 1'b0;
      q.push_back(e);
    end
  endtask
  task automatic step(input logic v, input logic d, input logic [3:0] m, input logic r, input logic f);
    @(posedge clk);
    if (acc_pend) push_req(acc_dir, acc_mask);
    acc_pend = 1'b0;
    #1;
    req_valid = v; req_vts = d; req_lane_mask = m; rr_ready = r; flush = f;
    @(negedge clk);
    if (rst_n && req_valid && req_ready && !flush) begin
      acc_pend = 1'b1; acc_dir = req_vts; acc_mask = req_lane_mask;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0, 1'b1, 1'b0);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_valid"}, rr_valid, 0);
    chk({n, "_select"}, rerouting_select, 0);
    chk({n, "_code"}, rerouting_code, 0);
    chk({n, "_last"}, rr_last, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
  endtask
  always @(negedge clk) begin
    logic exp_done, exp_busy;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      done_pend = 1'b0;
`ifdef RR_PERF_CNT_EN
      m_moves = 0; m_stalls = 0;
`endif
    end else begin
      exp_done = done_pend;
      done_pend = 1'b0;
      if (q.size() > 0 && q[0].empty) begin
        exp_done = 1'b1;
        void'(q.pop_front());
      end
      exp_busy = q.size() > 0;
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      chk("rr_valid", rr_valid, exp_busy);
      chk("select", rerouting_select, exp_busy);
      chk("req_ready", req_ready, !exp_busy);
`ifdef RR_PERF_CNT_EN
      chk("perf_moves", perf_moves, m_moves);
      chk("perf_stalls", perf_stalls, m_stalls);
`endif
      if (exp_busy) begin
        chk("code", rerouting_code, q[0].code);
        chk("last", rr_last, q[0].last);
        if (rr_ready) begin
          e = q.pop_front();
          if (e.last && !flush) done_pend = 1'b1;
`ifdef RR_PERF_CNT_EN
          m_moves++;
        end else begin
          m_stalls++;
`endif
        end
        if (flush) q.delete();
      end else begin
        chk("code_idle", rerouting_code, 0);
        chk("last_idle", rr_last, 0);
      end
    end
  end
  initial begin
    #1;
    chk_zero("reset");
    chk("reset_ready", req_ready, 1);
    idle(2);
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
    idle(6);
    step(1'b1, 1'b1, 4'b1010, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 4'b0111, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b0, 1'b1, 1'b1);
    idle(4);
    step(1'b1, 1'b0, 4'b1100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    chk("pre_reset_code", rerouting_code, 3'd2);
    #2 rst_n = 1'b0;
    acc_pend = 1'b0;
    #1;
    chk_zero("async_reset");
    idle(2);
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 24; i++)
      step(1'b1, i[0], 4'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    idle(5);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 2) != 0), 1'($urandom), 4'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    idle(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
